// File: rtl/tlul_host_rob_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tlul_host_rob_pkg
// Description : Shared types for the reordering TL-UL host adapter: TL-UL
//               channel structs, opcodes, slot state and slot record, and a
//               small integrity-code helper.
// Revision    : 1.0 - initial release
// ============================================================================
package tlul_host_rob_pkg;

  localparam int TL_AIW = 8;
  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_DBW = 4;

  localparam logic [3:0] MuBi4True  = 4'h6;
  localparam logic [3:0] MuBi4False = 4'h9;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic [3:0] instr_type;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  typedef struct packed {
    logic              a_valid;
    tl_a_op_e          a_opcode;
    logic [2:0]        a_param;
    logic [1:0]        a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    tl_a_user_t        a_user;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    tl_d_op_e          d_opcode;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;

  typedef enum logic [1:0] {
    SlotFree = 2'd0,
    SlotPend = 2'd1,
    SlotDone = 2'd2
  } slot_state_e;

  typedef struct packed {
    slot_state_e      state;
    logic [TL_DW-1:0] rdata;
    logic             err;
  } slot_t;

  // 7-bit integrity code: bit k is the XOR of every input bit whose index is
  // congruent to k modulo 7. Callers zero-extend their payload to 57 bits.
  function automatic logic [6:0] intg7(input logic [56:0] d);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 57; i++) begin
      c[3'(i % 7)] = c[3'(i % 7)] ^ d[i];
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tlul_host_rob_if.sv
`default_nettype none
// ============================================================================
// Module      : tlul_host_rob_if
// Description : Bundle of the core-side request/response signals and the
//               TL-UL host port of the reordering adapter.
// Revision    : 1.0 - initial release
// ============================================================================
interface tlul_host_rob_if;
  import tlul_host_rob_pkg::*;

  logic        req_i;
  logic        gnt_o;
  logic [31:0] addr_i;
  logic        we_i;
  logic [31:0] wdata_i;
  logic [3:0]  be_i;
  logic [3:0]  instr_type_i;
  logic        valid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        busy_o;
  logic        spurious_o;
  tl_h2d_t     tl_o;
  tl_d2h_t     tl_i;

  // Adapter view
  modport slave (
    input  req_i, addr_i, we_i, wdata_i, be_i, instr_type_i, tl_i,
    output gnt_o, valid_o, rdata_o, err_o, busy_o, spurious_o, tl_o
  );

  // Environment view (core plus crossbar)
  modport master (
    output req_i, addr_i, we_i, wdata_i, be_i, instr_type_i, tl_i,
    input  gnt_o, valid_o, rdata_o, err_o, busy_o, spurious_o, tl_o
  );
endinterface
`default_nettype wire

// File: rtl/tlul_host_rob_slots.sv
`default_nettype none
// ============================================================================
// Module      : tlul_host_rob_slots
// Description : Slot table, issue/retire pointers and in-order retire logic
//               of the reordering TL-UL host adapter.
// Revision    : 1.0 - initial release
// ============================================================================
module tlul_host_rob_slots
  import tlul_host_rob_pkg::*;
#(
  parameter int   MaxReqs = 4,
  parameter int   SrcW    = 2,
  parameter logic Bypass  = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            issue,
  output logic [SrcW-1:0] iptr,
  output logic            iptr_free,
  input  logic [SrcW-1:0] lk_idx,
  output logic            lk_pend,
  input  logic            wr_en,
  input  logic [SrcW-1:0] wr_idx,
  input  logic [31:0]     wr_data,
  input  logic            wr_err,
  output logic            valid,
  output logic [31:0]     rdata,
  output logic            err,
  output logic            busy
);

  // Table is sized to the full index range so any pointer value is a legal
  // index; entries at or above MaxReqs are never allocated.
  localparam int              Depth   = 1 << SrcW;
  localparam logic [SrcW-1:0] LastIdx = SrcW'(MaxReqs - 1);

  slot_t           slots [Depth];
  logic [SrcW-1:0] rptr;
  logic            head_done;
  logic            bypass_hit;

  function automatic logic [SrcW-1:0] ptr_next(input logic [SrcW-1:0] p);
    return (p == LastIdx) ? '0 : p + 1'b1;
  endfunction

  // Head-of-queue retire selection and table status lookups
  always_comb begin
    head_done  = (slots[rptr].state == SlotDone);
    bypass_hit = Bypass && wr_en && (wr_idx == rptr);
    valid      = head_done | bypass_hit;
    rdata      = '0;
    err        = 1'b0;
    if (head_done) begin
      rdata = slots[rptr].rdata;
      err   = slots[rptr].err;
    end else if (bypass_hit) begin
      rdata = wr_data;
      err   = wr_err;
    end
    iptr_free = (slots[iptr].state == SlotFree);
    lk_pend   = (slots[lk_idx].state == SlotPend);
    busy      = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      if (slots[i].state != SlotFree) busy = 1'b1;
    end
  end

  // Slot state updates; retire is applied last so a bypassed beat frees
  // its slot directly instead of parking it in DONE.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        slots[i] <= '{state: SlotFree, rdata: '0, err: 1'b0};
      end
      iptr <= '0;
      rptr <= '0;
    end else begin
      if (issue) begin
        slots[iptr].state <= SlotPend;
        iptr              <= ptr_next(iptr);
      end
      if (wr_en) begin
        slots[wr_idx] <= '{state: SlotDone, rdata: wr_data, err: wr_err};
      end
      if (valid) begin
        slots[rptr].state <= SlotFree;
        rptr              <= ptr_next(rptr);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tlul_host_rob.sv
`default_nettype none
// ============================================================================
// Module      : tlul_host_rob
// Description : TL-UL host adapter for a core memory port with up to MaxReqs
//               outstanding requests; out-of-order device responses are
//               retired to the core in issue order.
// Revision    : 1.0 - initial release
// ============================================================================
module tlul_host_rob
  import tlul_host_rob_pkg::*;
#(
  parameter int                     MaxReqs = 4,
  parameter int                     SrcW    = (MaxReqs > 1) ? $clog2(MaxReqs) : 1,
  parameter logic [TL_AIW-SrcW-1:0] SrcBase = '0,
  parameter logic                   Bypass  = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  tlul_host_rob_if.slave  bus
);

  logic [SrcW-1:0] iptr;
  logic            iptr_free;
  logic            a_valid;
  tl_a_op_e        a_opcode;
  logic [31:0]     a_address;
  logic [SrcW-1:0] d_idx;
  logic            d_base_ok;
  logic            d_in_range;
  logic            lk_pend;
  logic            accept;
  logic [31:0]     d_data_kept;
  logic            unused_addr_lsb;

  // Word-aligned address: the byte offset is carried by the mask only
  assign unused_addr_lsb = ^bus.addr_i[1:0];
  assign a_address       = {bus.addr_i[31:2], 2'b00};

  // Issue only into a slot that is FREE in registered state
  assign a_valid   = bus.req_i & iptr_free;
  assign bus.gnt_o = a_valid & bus.tl_i.a_ready;

  // Opcode from write enable and byte-enable coverage
  always_comb begin
    a_opcode = Get;
    if (bus.we_i) begin
      a_opcode = (bus.be_i == 4'hf) ? PutFullData : PutPartialData;
    end
  end

  // A-channel encode with command and data integrity
  always_comb begin
    bus.tl_o                   = '0;
    bus.tl_o.a_valid           = a_valid;
    bus.tl_o.a_opcode          = a_opcode;
    bus.tl_o.a_param           = 3'd0;
    bus.tl_o.a_size            = 2'd2;
    bus.tl_o.a_source          = {SrcBase, iptr};
    bus.tl_o.a_address         = a_address;
    bus.tl_o.a_mask            = bus.be_i;
    bus.tl_o.a_data            = bus.wdata_i;
    bus.tl_o.a_user.instr_type = bus.instr_type_i;
    bus.tl_o.a_user.cmd_intg   = intg7(57'({bus.instr_type_i, a_address, a_opcode, bus.be_i}));
    bus.tl_o.a_user.data_intg  = intg7(57'(bus.wdata_i));
    bus.tl_o.d_ready           = 1'b1;
  end

  // D-channel match: right source base, slot index in use and PEND
  assign d_idx       = bus.tl_i.d_source[SrcW-1:0];
  assign d_base_ok   = (bus.tl_i.d_source[TL_AIW-1:SrcW] == SrcBase);
  assign d_in_range  = ({1'b0, d_idx} < (SrcW+1)'(MaxReqs));
  assign accept      = bus.tl_i.d_valid & d_base_ok & d_in_range & lk_pend;
  assign bus.spurious_o = bus.tl_i.d_valid & ~accept;
  assign d_data_kept = (bus.tl_i.d_opcode == AccessAckData) ? bus.tl_i.d_data : '0;

  tlul_host_rob_slots #(
    .MaxReqs (MaxReqs),
    .SrcW    (SrcW),
    .Bypass  (Bypass)
  ) u_slots (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .issue     (bus.gnt_o),
    .iptr      (iptr),
    .iptr_free (iptr_free),
    .lk_idx    (d_idx),
    .lk_pend   (lk_pend),
    .wr_en     (accept),
    .wr_idx    (d_idx),
    .wr_data   (d_data_kept),
    .wr_err    (bus.tl_i.d_error),
    .valid     (bus.valid_o),
    .rdata     (bus.rdata_o),
    .err       (bus.err_o),
    .busy      (bus.busy_o)
  );

endmodule
`default_nettype wire
